adc_captura_spi: RTL and testbench



---
 rtl/adc_captura_spi_pkg.sv | 27 ++
 rtl/adc_captura_spi_if.sv | 38 +++
 rtl/adc_captura_spi_gen_tick_muestra.sv | 33 +++
 rtl/adc_captura_spi.sv | 156 +++++++++++++++
 tb/tb_adc_captura_spi.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/adc_captura_spi_pkg.sv
// Purpose: shared types and constants for the serial ADC capture front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a; the capture path has no ready, samples are strobed out.
//
// Contents: FSM state encoding, ADC frame geometry, offset-binary to signed helper.

package adc_captura_spi_pkg;

  // Frame sequencer states: idle, CS setup, 16-bit shift, publish.
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SETUP    = 2'd1,
    TRANSFER = 2'd2,
    FIN      = 2'd3
  } estado_t;

  localparam int ADC_BITS   = 12;
  localparam int TRAMA_BITS = 16;
  localparam int OFFSET     = 2048;

  // Offset-binary code to two's complement. Subtracting mid-scale modulo
  // 2^12 is the same as flipping the MSB, so this stays a single XOR.
  function automatic logic signed [ADC_BITS-1:0] a_signo(input logic [ADC_BITS-1:0] code);
    return $signed(code - ADC_BITS'(OFFSET));
  endfunction

endpackage

// File: rtl/adc_captura_spi_if.sv
// Purpose: bundles the ADC pins and the filter-side u/rx load bus.
// Latency: n/a (wiring only).
// Backpressure: none; rx is a strobe and the consumer must take u that cycle.
//
// Ports: en, sdata (into capture block); cs_n, sclk, rx, u, err_trama (out of it).
// master = capture block, slave = ADC + filter side.

interface adc_captura_spi_if #(
  parameter int cant_bits = 25
);
  logic                 en;
  logic                 sdata;
  logic                 cs_n;
  logic                 sclk;
  logic                 rx;
  logic [cant_bits-1:0] u;
  logic                 err_trama;

  modport master (
    input  en,
    input  sdata,
    output cs_n,
    output sclk,
    output rx,
    output u,
    output err_trama
  );

  modport slave (
    output en,
    output sdata,
    input  cs_n,
    input  sclk,
    input  rx,
    input  u,
    input  err_trama
  );
endinterface

// File: rtl/adc_captura_spi_gen_tick_muestra.sv
// Purpose: free-running sample-rate pacer, one tick per div_muestra cycles.
// Latency: first tick div_muestra cycles after reset release.
// Backpressure: none; ticks are never held or queued.
//
// Ports: clk, rst (async active-low), tick (high while counter == div_muestra-1).

module gen_tick_muestra #(
  parameter int div_muestra = 2268
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (div_muestra > 1) ? $clog2(div_muestra) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(div_muestra - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_captura_spi.sv
// Purpose: paces sampling, reads one 16-bit frame per period from an AD7476-class ADC, publishes signed fixed-point u with an rx strobe.
// Latency: tick at T -> cs_n low at T+1 -> rx high at T+33*div_sclk+2.
// Backpressure: none; u/rx is a one-cycle load strobe, u holds until the next frame.
//
// Ports: clk, rst (async active-low); bus (master modport): en, sdata in;
// cs_n, sclk (idles high), rx, u[cant_bits-1:0], err_trama out.

module adc_captura_spi
  import adc_captura_spi_pkg::*;
#(
  parameter int cant_bits   = 25,
  parameter int parte_frac  = 16,
  parameter int div_sclk    = 4,
  parameter int div_muestra = 2268
) (
  input  logic                clk,
  input  logic                rst,
  adc_captura_spi_if.master   bus
);

  localparam int FW    = (div_sclk > 1) ? $clog2(div_sclk) : 1;
  localparam int BW    = $clog2(TRAMA_BITS);
  // s/2048 in [-1,1): the 12-bit code already has 11 fractional bits.
  localparam int SHIFT = parte_frac - (ADC_BITS - 1);

  logic tick;

  gen_tick_muestra #(
    .div_muestra (div_muestra)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  estado_t                 estado_q, estado_d;
  logic [FW-1:0]           fase_q, fase_d;    // cycles spent in current sclk phase
  logic [BW-1:0]           bit_q, bit_d;      // bit index within the frame
  logic [TRAMA_BITS-1:0]   trama_q, trama_d;  // shift register, MSB first
  logic                    cs_n_q, cs_n_d;
  logic                    sclk_q, sclk_d;
  logic                    rx_q, rx_d;
  logic [cant_bits-1:0]    u_q, u_d;
  logic                    err_q, err_d;

  logic signed [ADC_BITS-1:0] muestra_s;
  logic [cant_bits-1:0]       muestra_ext;
  logic                       fin_fase;

  always_comb begin
    muestra_s   = a_signo(trama_q[ADC_BITS-1:0]);
    muestra_ext = {{(cant_bits - ADC_BITS){muestra_s[ADC_BITS-1]}}, muestra_s};
    fin_fase    = (fase_q == FW'(div_sclk - 1));

    estado_d = estado_q;
    fase_d   = fase_q;
    bit_d    = bit_q;
    trama_d  = trama_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    rx_d     = 1'b0;
    u_d      = u_q;
    err_d    = err_q;

    case (estado_q)
      REPOSO: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        if (tick && bus.en) begin
          estado_d = SETUP;
          cs_n_d   = 1'b0;
          fase_d   = '0;
        end
      end

      SETUP: begin
        if (fin_fase) begin
          estado_d = TRANSFER;
          sclk_d   = 1'b0;
          fase_d   = '0;
          bit_d    = '0;
        end else begin
          fase_d = fase_q + FW'(1);
        end
      end

      TRANSFER: begin
        // ADC drives a new bit on the falling edge; take it one cycle into
        // the high phase so it has had a full low phase to settle.
        if (sclk_q && (fase_q == '0)) begin
          trama_d = {trama_q[TRAMA_BITS-2:0], bus.sdata};
        end
        if (!fin_fase) begin
          fase_d = fase_q + FW'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          fase_d = '0;
        end else if (bit_q == BW'(TRAMA_BITS - 1)) begin
          estado_d = FIN;
          cs_n_d   = 1'b1;
          sclk_d   = 1'b1;
        end else begin
          sclk_d = 1'b0;
          fase_d = '0;
          bit_d  = bit_q + BW'(1);
        end
      end

      FIN: begin
        estado_d = REPOSO;
        rx_d     = 1'b1;
        u_d      = muestra_ext << SHIFT;
        // Leading zeros must be zero; the sample is still published so the
        // filter keeps its rate, the flag just tells software it is suspect.
        err_d    = |trama_q[TRAMA_BITS-1:ADC_BITS];
      end

      default: begin
        estado_d = REPOSO;
        cs_n_d   = 1'b1;
        sclk_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= REPOSO;
      fase_q   <= '0;
      bit_q    <= '0;
      trama_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      rx_q     <= 1'b0;
      u_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      fase_q   <= fase_d;
      bit_q    <= bit_d;
      trama_q  <= trama_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      rx_q     <= rx_d;
      u_q      <= u_d;
      err_q    <= err_d;
    end
  end

  assign bus.cs_n      = cs_n_q;
  assign bus.sclk      = sclk_q;
  assign bus.rx        = rx_q;
  assign bus.u         = u_q;
  assign bus.err_trama = err_q;

endmodule

// File: tb/tb_adc_captura_spi.sv
// Purpose: scoreboard bench for adc_captura_spi with an AD7476-style ADC model.
// Latency: checks cs_n/rx timing against the sample tick.
// Backpressure: n/a.

module tb_adc_captura_spi;

  localparam int DIV_M = 2268;
  localparam int LAT   = 133;   // cs_n fall (T+1) to rx (T+134)

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc_captura_spi_if #(.cant_bits(25)) bus ();

  adc_captura_spi #(
    .cant_bits   (25),
    .parte_frac  (16),
    .div_sclk    (4),
    .div_muestra (DIV_M)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [24:0] u;
    logic        err;
    int          gap;   // expected cycles since previous rx, 0 = unchecked
  } exp_t;
  exp_t q[$];

  task automatic push(input logic [24:0] u, input logic e, input int g);
    exp_t x;
    x.u = u; x.err = e; x.gap = g;
    q.push_back(x);
  endtask

  // ADC model: latches the frame at CS fall, drives one bit per SCLK fall.
  logic [15:0] adc_frame;
  logic [15:0] cur_frame;
  always begin
    @(negedge bus.cs_n);
    cur_frame = adc_frame;
    for (int i = 15; i >= 0; i--) begin
      @(negedge bus.sclk or posedge bus.cs_n);
      if (bus.cs_n) break;
      bus.sdata = cur_frame[i];
    end
  end

  // Monitor / scoreboard
  int   t_rel = 0;
  int   t_cs = 0, last_rx = -1, run = 0, nf = 0, nr = 0, n_cs_fall = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_rx = 1'b0, fall_seen = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      prev_cs = 1'b1; prev_sclk = 1'b1; prev_rx = 1'b0;
      run = 0; last_rx = -1; fall_seen = 1'b0;
    end else begin
      if (bus.cs_n) check("sclk_idle", {31'd0, bus.sclk}, 32'd1);
      if (!bus.cs_n) begin
        if (prev_cs) begin
          t_cs = cyc; n_cs_fall++; nf = 0; nr = 0; run = 1;
          if (!fall_seen) begin
            check("first_tick", cyc - t_rel, DIV_M);
            fall_seen = 1'b1;
          end
        end else if (bus.sclk !== prev_sclk) begin
          check("sclk_phase", run, 4);
          run = 1;
          if (bus.sclk) nr++; else nf++;
        end else begin
          run++;
        end
      end else if (!prev_cs) begin
        check("sclk_phase_last", run, 4);
        check("sclk_falls", nf, 16);
        check("sclk_rises", nr, 16);
      end
      if (bus.rx) begin
        check("rx_width", {31'd0, prev_rx}, 32'd0);
        if (q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL rx_unexpected: rx with u=0x%0h, expected no rx (cycle %0d)", bus.u, cyc);
        end else begin
          e = q.pop_front();
          check("u", {7'd0, bus.u}, {7'd0, e.u});
          check("err_trama", {31'd0, bus.err_trama}, {31'd0, e.err});
          check("latency", cyc - t_cs, LAT);
          if (e.gap != 0 && last_rx >= 0) check("rx_gap", cyc - last_rx, e.gap);
        end
        last_rx = cyc;
      end
      prev_cs = bus.cs_n; prev_sclk = bus.sclk; prev_rx = bus.rx;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, {31'd0, bus.cs_n}, 32'd1);
    check({tag, "_sclk"}, {31'd0, bus.sclk}, 32'd1);
    check({tag, "_rx"},   {31'd0, bus.rx},   32'd0);
    check({tag, "_u"},    {7'd0, bus.u},     32'd0);
    check({tag, "_err"},  {31'd0, bus.err_trama}, 32'd0);
  endtask

  int r;
  int nfall0;

  initial begin
    bus.en    = 1'b0;
    adc_frame = 16'h0800;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Release; frame k's cs_n falls at r + DIV_M*(k+1)
    t_rel = cyc; r = cyc;
    bus.en = 1'b1;
    push(25'h0000000, 1'b0, 0);
    rst = 1'b1;

    wait_until(r + DIV_M*1 + 1200);
    adc_frame = 16'h0FFF; push(25'h000FFE0, 1'b0, DIV_M);
    wait_until(r + DIV_M*2 + 1200);
    adc_frame = 16'h0000; push(25'h1FF0000, 1'b0, DIV_M);
    wait_until(r + DIV_M*3 + 1200);
    adc_frame = 16'h0001; push(25'h1FF0020, 1'b0, DIV_M);
    wait_until(r + DIV_M*4 + 1200);
    adc_frame = 16'h8ABC; push(25'h0005780, 1'b1, DIV_M);

    // Period 5 skipped by en=0
    wait_until(r + DIV_M*5 + 1200);
    bus.en = 1'b0;
    nfall0 = n_cs_fall;

    wait_until(r + DIV_M*6 + 1200);
    check("skip_no_cs", n_cs_fall, nfall0);
    bus.en = 1'b1;
    adc_frame = 16'h0123; push(25'h1FF2460, 1'b0, 2*DIV_M);

    // Drop en mid-TRANSFER; the frame must still complete
    wait_until(r + DIV_M*7 + 50);
    check("mid_frame_cs", {31'd0, bus.cs_n}, 32'd0);
    bus.en = 1'b0;

    wait_until(r + DIV_M*7 + 1200);
    bus.en = 1'b1;
    adc_frame = 16'h0FFF;   // aborted by reset, nothing expected

    // Reset during bit 7 low phase
    wait_until(r + DIV_M*8 + 62);
    check("pre_reset_cs", {31'd0, bus.cs_n}, 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");

    repeat (3) @(negedge clk);
    #1;
    adc_frame = 16'h0ABC; push(25'h0005780, 1'b0, 0);
    t_rel = cyc;
    rst = 1'b1;

    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
